// File: rtl/sync_shfifo_ctrl_pkg.sv
// sync_shfifo_ctrl_pkg: shared RAM latency, prefetch depth and prefetch pointer helpers
package sync_shfifo_ctrl_pkg;
  localparam int RD_LAT = 2;
  localparam int PF_DEPTH = 3;
  typedef logic [1:0] pf_ptr_t;
  function automatic pf_ptr_t pf_inc(input pf_ptr_t p);
    return (p == pf_ptr_t'(PF_DEPTH - 1)) ? pf_ptr_t'(0) : p + pf_ptr_t'(1);
  endfunction
endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM with a two-stage registered read path
module sdp_ram #(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      wen,
  input  logic [RAM_ADDR_WIDTH-1:0] waddr,
  input  logic [RAM_DATA_WIDTH-1:0] wdat,
  input  logic                      ren,
  input  logic [RAM_ADDR_WIDTH-1:0] raddr,
  output logic [RAM_DATA_WIDTH-1:0] q
);
  logic [RAM_DATA_WIDTH-1:0] mem [1 << RAM_ADDR_WIDTH];
  logic [RAM_DATA_WIDTH-1:0] rd_q, q_q;
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdat;
    if (ren) rd_q <= mem[raddr];
    q_q <= rd_q;
  end
  assign q = q_q;
endmodule

// File: rtl/sync_shfifo_ctrl.sv
// sync_shfifo_ctrl: show-ahead FIFO controller around sdp_ram with a 3-entry prefetch buffer
module sync_shfifo_ctrl
  import sync_shfifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  full,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int LW = ADDR_WIDTH + 2;
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] ram_cnt_q, ram_cnt_d;
  logic [LW-1:0] level_q, level_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  pf_ptr_t head_q, head_d, tail_q, tail_d, buf_cnt_q, buf_cnt_d, inflight;
  logic [DATA_WIDTH-1:0] pf_q [PF_DEPTH];
  logic [DATA_WIDTH-1:0] pf_d [PF_DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic full_q, full_d, empty_q, empty_d, ovf_q, ovf_d, unf_q, unf_d;
  logic push_acc, pop_acc, issue, cap;
  assign push_acc = push && !full_q;
  assign pop_acc  = pop && !empty_q;
  assign inflight = pf_ptr_t'($countones(vld_q));
  // Credit counts the slot an accepted pop frees this cycle, so a full buffer can refill back-to-back
  assign issue = (ram_cnt_q != '0) &&
                 (int'(buf_cnt_q) + int'(inflight) - int'(pop_acc) < PF_DEPTH);
  assign cap = vld_q[RD_LAT-1];
  always_comb begin
    wptr_d    = push_acc ? wptr_q + ADDR_WIDTH'(1) : wptr_q;
    rptr_d    = issue ? rptr_q + ADDR_WIDTH'(1) : rptr_q;
    ram_cnt_d = ram_cnt_q + CW'(push_acc) - CW'(issue);
    level_d   = level_q + LW'(push_acc) - LW'(pop_acc);
    vld_d     = {vld_q[RD_LAT-2:0], issue};
    head_d    = pop_acc ? pf_inc(head_q) : head_q;
    tail_d    = cap ? pf_inc(tail_q) : tail_q;
    buf_cnt_d = buf_cnt_q + pf_ptr_t'(cap) - pf_ptr_t'(pop_acc);
    for (int i = 0; i < PF_DEPTH; i++) pf_d[i] = (cap && tail_q == pf_ptr_t'(i)) ? ram_q : pf_q[i];
    full_d    = ram_cnt_d == CW'(RAM_DEPTH);
    empty_d   = buf_cnt_d == '0;
    ovf_d     = push && full_q;
    unf_d     = pop && empty_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      level_q   <= '0;
      vld_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      buf_cnt_q <= '0;
      for (int i = 0; i < PF_DEPTH; i++) pf_q[i] <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      level_q   <= level_d;
      vld_q     <= vld_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      buf_cnt_q <= buf_cnt_d;
      pf_q      <= pf_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end
  sdp_ram #(
    .RAM_DATA_WIDTH(DATA_WIDTH),
    .RAM_ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .wen  (push_acc && !rst),
    .waddr(wptr_q),
    .wdat (push_data),
    .ren  (issue && !rst),
    .raddr(rptr_q),
    .q    (ram_q)
  );
  assign full      = full_q;
  assign empty     = empty_q;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign pop_data  = pf_q[head_q];
endmodule
